// File: rtl/change_logger_pkg.sv
// rtl/change_logger_pkg.sv - default sizes and entry type for the change logger
package change_logger_pkg;
  localparam int DW_DEF    = 3;
  localparam int TSW_DEF   = 16;
  localparam int DEPTH_DEF = 8;
  localparam int EW_DEF    = TSW_DEF + 2 * DW_DEF;

  // {ts, a1, a2}: timestamp in the MSBs, a2 in the LSBs
  typedef logic [EW_DEF-1:0] entry_t;
endpackage

// File: rtl/log_fifo.sv
// rtl/log_fifo.sv - synchronous log FIFO; a push into a full FIFO is accepted only alongside a pop
module log_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Storage is not reset, so the output is masked to zero while nothing is queued
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/change_logger.sv
// rtl/change_logger.sv - timestamped change logger for two observed signals
// Optional drop counter output enabled by CHANGE_LOGGER_DROP_CNT_EN.
module change_logger
  import change_logger_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int TSW   = TSW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DW-1:0]            a1_i,
  input  logic [DW-1:0]            a2_i,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TSW+2*DW-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef CHANGE_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);
  localparam int EW = TSW + 2 * DW;

  logic [TSW-1:0] ts_cnt;
  logic [TSW-1:0] s_ts;
  logic [DW-1:0]  s1, s2, p1, p2;
  logic           armed;
  logic           prime;
  logic           change;
  logic           full;
  logic           empty;
  logic           drop;

  // prime marks the cycle in which s1/s2 hold the first sample after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      s_ts   <= '0;
      s1     <= '0;
      s2     <= '0;
      p1     <= '0;
      p2     <= '0;
      armed  <= 1'b1;
      prime  <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      s_ts   <= ts_cnt;
      s1     <= a1_i;
      s2     <= a2_i;
      p1     <= s1;
      p2     <= s2;
      armed  <= 1'b0;
      prime  <= armed;
    end
  end

  assign change   = prime || ({s1, s2} != {p1, p2});
  assign drop     = change && full && !rd_ready;
  assign rd_valid = !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef CHANGE_LOGGER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

  log_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (change),
    .push_data ({s_ts, s1, s2}),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );
endmodule

// File: tb/tb_change_logger.sv
// tb/tb_change_logger.sv - directed self-checking bench for change_logger
module tb_change_logger;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  a1 = '0;
  logic [2:0]  a2 = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [21:0] rd_data;
  logic [3:0]  level;
  logic        ovf;
  logic        ovf_clr = 1'b0;
`ifdef CHANGE_LOGGER_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [21:0] exp_q [8];
  logic [21:0] exp_new;
  logic [2:0]  v;

  change_logger dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a1_i     (a1),
    .a2_i     (a2),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef CHANGE_LOGGER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Edges since reset release; input driven now is sampled with ts == cyc
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [21:0] mk(input int ts, input logic [2:0] x1, input logic [2:0] x2);
    return {16'(ts), x1, x2};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check("rst_valid", 32'(rd_valid), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_data", 32'(rd_data), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));

    // prime entry only
    rst_n = 1'b1;
    step(1);
    check("prime_lat", 32'(rd_valid), 32'(0));
    step(4);
    check("prime_level", 32'(level), 32'(1));
    check("prime_data", 32'(rd_data), 32'(mk(0, 3'd0, 3'd0)));

    // two changes at ts 7 and 12 with consumer ready
    rd_ready = 1'b1;
    step(1);
    check("drain_level", 32'(level), 32'(0));
    step(7 - cyc);
    a1 = 3'd1;
    step(1);
    check("c1_lat1", 32'(rd_valid), 32'(0));
    step(1);
    check("c1_valid", 32'(rd_valid), 32'(1));
    check("c1_data", 32'(rd_data), 32'(mk(7, 3'd1, 3'd0)));
    step(12 - cyc);
    a2 = 3'd2;
    step(1);
    check("c2_lat1", 32'(rd_valid), 32'(0));
    step(1);
    check("c2_valid", 32'(rd_valid), 32'(1));
    check("c2_data", 32'(rd_data), 32'(mk(12, 3'd1, 3'd2)));
    step(1);
    rd_ready = 1'b0;

    // ten changes into an 8-deep FIFO
    for (int k = 0; k < 10; k++) begin
      v = 3'(k + 2);
      a1 = v;
      if (k < 8) exp_q[k] = mk(cyc, v, 3'd2);
      step(1);
      if (k == 8) check("ovf_before9", 32'(ovf), 32'(0));
      if (k == 9) check("ovf_after9", 32'(ovf), 32'(1));
    end
    step(2);
    check("full_level", 32'(level), 32'(8));
    check("full_ovf", 32'(ovf), 32'(1));
`ifdef CHANGE_LOGGER_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), 32'(2));
`endif
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'(0));
`ifdef CHANGE_LOGGER_DROP_CNT_EN
    check("drop_cnt_clr", 32'(drop_cnt), 32'(0));
`endif

    // push into full FIFO with simultaneous pop
    a1 = 3'd4;
    exp_new = mk(cyc, 3'd4, 3'd2);
    step(1);
    check("hold_data", 32'(rd_data), 32'(exp_q[0]));
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    check("pp_level", 32'(level), 32'(8));
    check("pp_ovf", 32'(ovf), 32'(0));
    rd_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(rd_data), 32'(exp_q[i]));
      step(1);
    end
    check("drain_new", 32'(rd_data), 32'(exp_new));
    step(1);
    check("drained", 32'(level), 32'(0));
    rd_ready = 1'b0;

    // reset with five entries queued
    for (int k = 0; k < 5; k++) begin
      a2 = 3'(k + 3);
      step(1);
    end
    step(1);
    check("q5_level", 32'(level), 32'(5));
    a1 = 3'd5;
    a2 = 3'd3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 32'(0));
    check("mid_rst_level", 32'(level), 32'(0));
    check("mid_rst_ovf", 32'(ovf), 32'(0));
    check("mid_rst_data", 32'(rd_data), 32'(0));
    step(1);
    rst_n = 1'b1;
    step(1);
    check("re_prime_lat", 32'(rd_valid), 32'(0));
    step(1);
    check("re_prime_level", 32'(level), 32'(1));
    check("re_prime_data", 32'(rd_data), 32'(mk(0, 3'd5, 3'd3)));
    step(3);
    check("re_prime_only", 32'(level), 32'(1));

    // timestamp wrap
    rd_ready = 1'b1;
    step(1);
    step(65535 - cyc);
    a1 = 3'd6;
    step(1);
    a1 = 3'd7;
    step(1);
    check("wrap_valid", 32'(rd_valid), 32'(1));
    check("wrap_hi", 32'(rd_data), 32'(mk(65535, 3'd6, 3'd3)));
    step(1);
    check("wrap_lo", 32'(rd_data), 32'(mk(0, 3'd7, 3'd3)));
    step(1);
    check("wrap_drained", 32'(level), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/change_logger.md
CHANGE_LOGGER -- requirements
Module: change_logger

Interface
REQ-001 Parameter DW, default 3, width of each observed signal.
REQ-002 Parameter TSW, default 16, timestamp width.
REQ-003 Parameter DEPTH, default 8, log-FIFO entries (power of 2, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 a1_i  input  DW  observed signal 1.
REQ-007 a2_i  input  DW  observed signal 2.
REQ-008 rd_valid  output  1  log entry available at rd_data.
REQ-009 rd_ready  input  1  consumer accepts entry.
REQ-010 rd_data  output  TSW+2*DW  entry {ts, a1, a2}; ts in MSBs, a2 in LSBs.
REQ-011 level  output  log2(DEPTH)+1  current entry count.
REQ-012 ovf  output  1  sticky: an entry was dropped.
REQ-013 ovf_clr  input  1  clears ovf.

Function
REQ-014 Timestamp counter ts_cnt SHALL increment by 1 every cycle, wrapping 2^TSW-1 -> 0.
REQ-015 Inputs SHALL be registered into sample regs s1/s2 every cycle; the ts tagged on an entry is ts_cnt at that sampling edge.
REQ-016 The first sample after reset deassertion SHALL always generate an entry (prime event), whatever its value.
REQ-017 Thereafter an entry SHALL be generated when {s1,s2} differs from the previous sample in any bit; equal samples generate nothing.
REQ-018 Entry push SHALL occur at the edge after sampling; rd_valid rises the same edge if FIFO was empty (latency 2 edges from input change to rd_valid).
REQ-019 rd_valid = (level != 0); rd_data SHALL show oldest entry and stay stable while rd_valid && !rd_ready.
REQ-020 Pop occurs when rd_valid && rd_ready at a clock edge.
REQ-021 Push while full without simultaneous pop SHALL drop the new entry and set ovf; FIFO contents unchanged.
REQ-022 Push while full with simultaneous pop SHALL accept the push; level stays DEPTH; ovf unchanged.
REQ-023 Push and pop when empty: push accepted, no pop (rd_valid was 0); level becomes 1.
REQ-024 ovf_clr SHALL clear ovf; if a drop occurs in the same cycle, set wins.
REQ-025 Pointers SHALL wrap modulo DEPTH; level never exceeds DEPTH.

Reset
REQ-026 rst_n low SHALL immediately force: ts_cnt=0, s1=s2=0, prime flag armed, pointers=0, level=0, rd_valid=0, rd_data=0, ovf=0.
REQ-027 Reset mid-operation SHALL discard all stored entries; no partial entry survives.

Configuration
REQ-028 Macro CHANGE_LOGGER_DROP_CNT_EN defined: adds output drop_cnt (8 bits), incremented per dropped entry, saturating at 255, cleared by ovf_clr (increment wins on same cycle), reset 0.
REQ-029 Macro undefined: no drop_cnt port or logic; only sticky ovf reports drops.

Structure
REQ-030 Package change_logger_pkg SHALL hold default DW/TSW/DEPTH constants and the entry width/typedef.
REQ-031 Storage SHALL be a sub-module log_fifo (synchronous FIFO, push/pop/full/empty/level); change detection and timestamping stay in change_logger.

Verification
REQ-032 Reset release, a1=0,a2=0 held, rd_ready=0 -> exactly one prime entry {ts=0,0,0} (or the ts of the first sample edge), level=1, no further entries.
REQ-033 a1 0->1 at ts 7, a2 0->2 at ts 12, rd_ready=1 -> entries {7,1,0},{12,1,2} in order, rd_valid 2 edges after each change.
REQ-034 rd_ready=0, 10 changes with DEPTH=8 -> level=8, ovf=1 after 9th change, first 8 entries intact; drop_cnt=2 with macro.
REQ-035 FIFO full, change with rd_ready=1 same cycle -> push accepted, level stays 8, ovf stays 0.
REQ-036 ts_cnt near 2^16-1, change across wrap -> entry ts values 65535 then 0.
REQ-037 rst_n pulsed low mid-stream with 5 entries queued -> rd_valid=0, level=0, ovf=0 immediately; new prime entry after release.
